// File: rtl/sram_port0_ctrl.sv
// Valid/ready front end for the RW port of the 32x512 OpenRAM macro; registered macro drive, in-order read FIFO.
// Optional power-up zero fill of the whole array when SRAM_CLEAR_EN is defined.
module sram_port0_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  init_done,
    output logic                  busy
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int CW        = $clog2(RSP_DEPTH + 3);
    localparam int PW        = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr, clr_addr_next;

    logic                    csb_d, web_d;
    logic [NUM_WMASKS-1:0]   wmask_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   din_d;

    logic                    accept;
    logic                    rd_issue;
    logic [1:0]              rd_pipe;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic                    push, pop;
    logic [DATA_WIDTH-1:0]   fifo_mem [RSP_DEPTH];

    assign init_done = (state == ST_RUN);
    assign inflight  = CW'(rd_pipe[0]) + CW'(rd_pipe[1]);
    // Credit covers every read already issued, so a push never finds the FIFO full.
    assign req_ready = init_done && ((inflight + fifo_count) < CW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign rd_issue  = accept && !req_we;
    assign push      = rd_pipe[1];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = fifo_mem[rd_ptr];
    assign busy      = (inflight != '0) || (fifo_count != '0);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
`ifdef SRAM_CLEAR_EN
            state    <= ST_CLEAR;
`else
            state    <= ST_RUN;
`endif
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        csb_d         = 1'b1;
        web_d         = 1'b1;
        wmask_d       = sram_wmask0;
        addr_d        = sram_addr0;
        din_d         = sram_din0;
        unique case (state)
            ST_CLEAR: begin
                csb_d         = 1'b0;
                web_d         = 1'b0;
                wmask_d       = '1;
                din_d         = '0;
                addr_d        = clr_addr;
                clr_addr_next = clr_addr + 1'b1;
                if (clr_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    csb_d  = 1'b0;
                    web_d  = ~req_we;
                    addr_d = req_addr;
                    if (req_we) begin
                        din_d   = req_wdata;
                        wmask_d = req_wmask;
                    end else begin
                        wmask_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else begin
            sram_csb0   <= csb_d;
            sram_web0   <= web_d;
            sram_wmask0 <= wmask_d;
            sram_addr0  <= addr_d;
            sram_din0   <= din_d;
        end
    end

    // Stage 0: macro samples at the next edge; stage 1: dout valid, captured at the following edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= {rd_pipe[0], rd_issue};
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sram_dout0;
        end
    end

endmodule

// File: doc/sram_port0_ctrl.md
Name: sram_port0_ctrl

Overview:
- Single-clock initiator that drives the RW port (port 0) of the 32x512 OpenRAM SRAM macro from a valid/ready request/response interface.
- Registers all macro control, address and data outputs.
- Tracks the macro's fixed read latency and returns read data in order through a response FIFO.
- Issues no read unless response space is guaranteed.
- Sits between a bus slave (Wishbone/CPU data port) and the macro instance.

Parameters:
- ADDR_WIDTH, 9, macro word-address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- DATA_WIDTH, 32, macro data width.
- NUM_WMASKS, 4, byte-write mask width (DATA_WIDTH/8).
- RSP_DEPTH, 2, response FIFO entries; also the read-credit limit (min 2).

Ports:
- wb_clk_i  in  1  sole clock; also drives the macro clk0.
- wb_rst_i  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid and req_ready are both high at posedge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  NUM_WMASKS  byte enables for writes.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  DATA_WIDTH  read data, FIFO head.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_wmask0  out  NUM_WMASKS  macro write mask.
- sram_addr0  out  ADDR_WIDTH  macro address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_dout0  in  DATA_WIDTH  macro read data.
- init_done  out  1  controller accepting requests.
- busy  out  1  read in flight or response FIFO non-empty.

Behaviour:
- Reset (async, immediate):
  - sram_csb0=1, sram_web0=1; wmask0, addr0, din0 = 0.
  - In-flight reads discarded; FIFO emptied; rsp_valid=0; busy=0.
- req_ready = init_done AND (inflight + fifo_count < RSP_DEPTH).
  - Combinational from internal state only; never depends on req_valid or req_we.
- Accept at posedge E0 drives, for the cycle after E0:
  - csb0=0; web0 = ~req_we; addr0 = req_addr.
  - Write: din0 = req_wdata, wmask0 = req_wmask.
  - Read: wmask0 = 0; din0 holds its previous value.
- If no request is accepted at an edge, csb0 returns to 1 (and web0 to 1) for the next cycle.
- Back-to-back accepts are allowed, one per cycle.
- Read timing:
  - Macro samples at E1.
  - Controller pushes sram_dout0 into the FIFO at E2.
  - rsp_valid rises after E2: 2-cycle latency from accept to rsp_valid with an empty FIFO.
- Read tracking: 2-stage valid shift register.
  - inflight = number of set stages (0..2).
  - The credit check guarantees the FIFO is never full at a push.
- Writes take no FIFO entry and produce no response.
  - Writes still wait on req_ready when credit is exhausted.
  - wmask=0 writes are issued unchanged (macro no-op).
- FIFO:
  - In-order.
  - Simultaneous push and pop are allowed in any state, including empty and full.
  - Pop occurs on rsp_valid AND rsp_ready.
  - rsp_rdata is stable while rsp_valid=1 and rsp_ready=0.
- Ordering: a read accepted the cycle after a write to the same address returns the new data. No stall or forwarding is needed because the macro writes on the negedge of the sample edge.
- busy = (inflight != 0) OR (fifo_count != 0).
- Counters are sized to hold 0..RSP_DEPTH and never wrap.

Optional Feature:
- Macro: SRAM_CLEAR_EN.
- Defined:
  - Reset enters CLEAR state with init_done=0 and req_ready=0.
  - One write per cycle: csb0=0, web0=0, wmask0=all ones, din0=0, addr0 = 0..RAM_DEPTH-1.
  - After address RAM_DEPTH-1 is issued, the next edge enters RUN and init_done=1.
  - Clear takes exactly RAM_DEPTH cycles.
  - Reset mid-clear restarts at address 0.
- Undefined: reset state is RUN; init_done reset value is 1; no clear sequence.

Test Plan:
- Write addr 5 data 0xDEADBEEF mask 4'hF, then read 5 with rsp_ready=1 → csb0 low one cycle per op; rsp_valid 2 cycles after read accept; rdata 0xDEADBEEF.
- Write addr 7 = 0x11223344, then write addr 7 = 0xAABBCCDD with mask 4'b0101, then read 7 → 0x11BB33DD.
- rsp_ready=0, issue 3 reads to addrs 1,2,3 holding 0xA,0xB,0xC → third stalls (req_ready=0 with 2 credits used); raise rsp_ready → responses 0xA,0xB,0xC in order; third issues after first pop.
- Write addr 9 = 0x55 then read 9 on the very next cycle → returns 0x55.
- Assert wb_rst_i while 2 reads are in flight → csb0=1 and rsp_valid=0 immediately; no stale response after release; busy=0.
- SRAM_CLEAR_EN defined, memory preloaded with 0xFFFFFFFF → init_done rises 512 cycles after reset release; read addr 0 and addr 511 both return 0.
